// File: rtl/dbus_ctrl.sv
// Data-bus controller: routes core loads/stores to dmem or to the AXI-lite engine, one response per request.
// DMEM responds 1 cycle after accept; AXI-lite responds 1 cycle after DONE or after a bounded timeout with ERR.
module dbus_ctrl #(
   parameter int DMEM_ADDR_WIDTH = 10,
   parameter int AXIL_TIMEOUT    = 255
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       REQ_VALID,
   output logic                       REQ_READY,
   input  logic [31:0]                REQ_ADDR,
   input  logic [31:0]                REQ_WDATA,
   input  logic [3:0]                 REQ_WMASK,
   output logic                       RSP_VALID,
   output logic [31:0]                RSP_RDATA,
   output logic                       RSP_ERR,
   output logic                       DMEM_EN,
   output logic [3:0]                 DMEM_WMASK,
   output logic [DMEM_ADDR_WIDTH-1:0] DMEM_ADDR,
   output logic [31:0]                DMEM_WDATA,
   input  logic [31:0]                DMEM_RDATA,
   output logic                       AXIL_START_READ,
   output logic                       AXIL_START_WRITE,
   input  logic                       AXIL_BUSY_READ,
   input  logic                       AXIL_BUSY_WRITE,
   input  logic                       AXIL_DONE_READ,
   input  logic                       AXIL_DONE_WRITE,
   output logic [31:0]                AXIL_TRANSACTION_RADDR,
   output logic [31:0]                AXIL_TRANSACTION_WRADDR,
   output logic [31:0]                AXIL_TRANSACTION_WRDATA,
   output logic [3:0]                 AXIL_TRANSACTION_WSTRB,
   input  logic [31:0]                AXIL_TRANSACTION_RDATA
);

   typedef enum logic [2:0] {IDLE, DMEM_RSP, AXIL_RD, AXIL_WR, AXIL_RSP} state_t;

   localparam logic [15:0] TIMEOUT_CNT = 16'(AXIL_TIMEOUT);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic        is_dmem;
   logic        is_write;
   logic        busy_sel;
   logic        accept;
   logic        wait_done;
   logic        timed_out;
   logic        dmem_write;
   logic [31:0] rdata_lat;
   logic        err_lat;

   assign is_dmem   = (REQ_ADDR[31:DMEM_ADDR_WIDTH+2] == '0);
   assign is_write  = |REQ_WMASK;
   assign busy_sel  = is_write ? AXIL_BUSY_WRITE : AXIL_BUSY_READ;
   assign REQ_READY = ~RST & (state == IDLE) & (is_dmem | ~busy_sel);
   assign accept    = REQ_VALID & REQ_READY;

   assign DMEM_EN    = accept & is_dmem;
   assign DMEM_WMASK = DMEM_EN ? REQ_WMASK : 4'b0;
   assign DMEM_ADDR  = REQ_ADDR[DMEM_ADDR_WIDTH+1:2];
   assign DMEM_WDATA = REQ_WDATA;

   // DONE only counts on the channel we are actually waiting for; it beats a same-cycle timeout.
   assign wait_done = ((state == AXIL_RD) & AXIL_DONE_READ) | ((state == AXIL_WR) & AXIL_DONE_WRITE);
   assign timed_out = (cnt >= TIMEOUT_CNT);

   always_comb begin
      state_nxt = state;
      RSP_VALID = 1'b0;
      RSP_RDATA = '0;
      RSP_ERR   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = is_dmem ? DMEM_RSP : (is_write ? AXIL_WR : AXIL_RD);
         end
         DMEM_RSP: begin
            RSP_VALID = 1'b1;
            RSP_RDATA = dmem_write ? '0 : DMEM_RDATA;
            state_nxt = IDLE;
         end
         AXIL_RD, AXIL_WR: begin
            if (wait_done | timed_out) state_nxt = AXIL_RSP;
         end
         AXIL_RSP: begin
            RSP_VALID = 1'b1;
            RSP_RDATA = rdata_lat;
            RSP_ERR   = err_lat;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state                   <= IDLE;
         cnt                     <= '0;
         dmem_write              <= 1'b0;
         rdata_lat               <= '0;
         err_lat                 <= 1'b0;
         AXIL_START_READ         <= 1'b0;
         AXIL_START_WRITE        <= 1'b0;
         AXIL_TRANSACTION_RADDR  <= '0;
         AXIL_TRANSACTION_WRADDR <= '0;
         AXIL_TRANSACTION_WRDATA <= '0;
         AXIL_TRANSACTION_WSTRB  <= '0;
      end else begin
         state            <= state_nxt;
         AXIL_START_READ  <= accept & ~is_dmem & ~is_write;
         AXIL_START_WRITE <= accept & ~is_dmem & is_write;
         if (accept) dmem_write <= is_write;
         if (accept & ~is_dmem) begin
            AXIL_TRANSACTION_RADDR  <= REQ_ADDR;
            AXIL_TRANSACTION_WRADDR <= REQ_ADDR;
            AXIL_TRANSACTION_WRDATA <= REQ_WDATA;
            AXIL_TRANSACTION_WSTRB  <= REQ_WMASK;
            cnt                     <= '0;
         end else if ((state == AXIL_RD) || (state == AXIL_WR)) begin
            if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            if (wait_done) begin
               rdata_lat <= (state == AXIL_RD) ? AXIL_TRANSACTION_RDATA : '0;
               err_lat   <= 1'b0;
            end else if (timed_out) begin
               rdata_lat <= '0;
               err_lat   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Randomized self-checking bench for dbus_ctrl against a transaction-level reference model.
module tb_dbus_ctrl;

   localparam int AW = 10;
   localparam int TO = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic          REQ_VALID;
   logic          REQ_READY;
   logic [31:0]   REQ_ADDR;
   logic [31:0]   REQ_WDATA;
   logic [3:0]    REQ_WMASK;
   logic          RSP_VALID;
   logic [31:0]   RSP_RDATA;
   logic          RSP_ERR;
   logic          DMEM_EN;
   logic [3:0]    DMEM_WMASK;
   logic [AW-1:0] DMEM_ADDR;
   logic [31:0]   DMEM_WDATA;
   logic [31:0]   DMEM_RDATA;
   logic          AXIL_START_READ;
   logic          AXIL_START_WRITE;
   logic          AXIL_BUSY_READ;
   logic          AXIL_BUSY_WRITE;
   logic          AXIL_DONE_READ;
   logic          AXIL_DONE_WRITE;
   logic [31:0]   AXIL_TRANSACTION_RADDR;
   logic [31:0]   AXIL_TRANSACTION_WRADDR;
   logic [31:0]   AXIL_TRANSACTION_WRDATA;
   logic [3:0]    AXIL_TRANSACTION_WSTRB;
   logic [31:0]   AXIL_TRANSACTION_RDATA;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ref_mem [0:(1<<AW)-1];
   logic [31:0] dmem_arr [0:(1<<AW)-1];
   bit          mem_ready;

   always #5 CLK = ~CLK;

   dbus_ctrl #(.DMEM_ADDR_WIDTH(AW), .AXIL_TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
      .REQ_WDATA(REQ_WDATA), .REQ_WMASK(REQ_WMASK),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .DMEM_EN(DMEM_EN), .DMEM_WMASK(DMEM_WMASK), .DMEM_ADDR(DMEM_ADDR),
      .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA),
      .AXIL_START_READ(AXIL_START_READ), .AXIL_START_WRITE(AXIL_START_WRITE),
      .AXIL_BUSY_READ(AXIL_BUSY_READ), .AXIL_BUSY_WRITE(AXIL_BUSY_WRITE),
      .AXIL_DONE_READ(AXIL_DONE_READ), .AXIL_DONE_WRITE(AXIL_DONE_WRITE),
      .AXIL_TRANSACTION_RADDR(AXIL_TRANSACTION_RADDR),
      .AXIL_TRANSACTION_WRADDR(AXIL_TRANSACTION_WRADDR),
      .AXIL_TRANSACTION_WRDATA(AXIL_TRANSACTION_WRDATA),
      .AXIL_TRANSACTION_WSTRB(AXIL_TRANSACTION_WSTRB),
      .AXIL_TRANSACTION_RDATA(AXIL_TRANSACTION_RDATA)
   );

   // Synchronous dmem: contents cleared once during the first reset, then kept across resets.
   always @(posedge CLK) begin
      if (RST && !mem_ready) begin
         for (int i = 0; i < (1<<AW); i++) dmem_arr[i] <= 32'h0;
         mem_ready <= 1'b1;
      end else if (DMEM_EN) begin
         DMEM_RDATA <= dmem_arr[DMEM_ADDR];
         for (int b = 0; b < 4; b++)
            if (DMEM_WMASK[b]) dmem_arr[DMEM_ADDR][8*b +: 8] <= DMEM_WDATA[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One complete request. delay = cycles from START to the matching DONE (beyond the window = never).
   task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wmask,
                          input int delay, input int busy_n, input logic [31:0] ax_rdata,
                          input bit wrong_done);
      bit          dm, wr, exp_err;
      int          lat, idx;
      logic [31:0] exp_rd;
      dm  = (addr[31:AW+2] == 0);
      wr  = (wmask != 4'b0);
      idx = int'(addr[AW+1:2]);
      REQ_ADDR = addr; REQ_WDATA = wdata; REQ_WMASK = wmask; REQ_VALID = 1'b1;
      if (dm) begin
         AXIL_BUSY_READ = busy_n[0]; AXIL_BUSY_WRITE = busy_n[1];
      end else begin
         for (int i = 0; i < busy_n; i++) begin
            AXIL_BUSY_WRITE = wr; AXIL_BUSY_READ = !wr;
            @(negedge CLK);
            chk("ready_while_busy", 32'(REQ_READY), 32'd0);
            tick();
         end
         AXIL_BUSY_WRITE = !wr; AXIL_BUSY_READ = wr;
      end
      @(negedge CLK);
      chk("ready_accept", 32'(REQ_READY), 32'd1);
      chk("dmem_en", 32'(DMEM_EN), 32'(dm));
      chk("dmem_wmask", 32'(DMEM_WMASK), dm ? 32'(wmask) : 32'd0);
      if (dm) chk("dmem_addr", 32'(DMEM_ADDR), 32'(idx));
      if (dm) begin
         exp_rd  = wr ? 32'h0 : ref_mem[idx];
         exp_err = 1'b0;
         lat     = 1;
         for (int b = 0; b < 4; b++)
            if (wmask[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
         exp_err = (delay > TO);
         lat     = 2 + ((delay > TO) ? TO : delay);
         exp_rd  = (exp_err || wr) ? 32'h0 : ax_rdata;
      end
      tick();
      REQ_VALID = 1'b0; AXIL_BUSY_READ = 1'b0; AXIL_BUSY_WRITE = 1'b0;
      for (int k = 1; k <= lat + 2; k++) begin
         if (!dm) begin
            AXIL_DONE_READ  = (!wr && k == delay + 1) || (wr && wrong_done && k == 2);
            AXIL_DONE_WRITE = (wr && k == delay + 1) || (!wr && wrong_done && k == 2);
            AXIL_TRANSACTION_RDATA = (k == delay + 1) ? ax_rdata : $urandom();
         end
         @(negedge CLK);
         if (!dm && k == 1) begin
            chk("start_read", 32'(AXIL_START_READ), 32'(!wr));
            chk("start_write", 32'(AXIL_START_WRITE), 32'(wr));
            chk("raddr", AXIL_TRANSACTION_RADDR, addr);
            chk("wraddr", AXIL_TRANSACTION_WRADDR, addr);
            chk("wrdata", AXIL_TRANSACTION_WRDATA, wdata);
            chk("wstrb", 32'(AXIL_TRANSACTION_WSTRB), 32'(wmask));
         end
         if (!dm && k == 2) chk("start_one_cycle", 32'({AXIL_START_READ, AXIL_START_WRITE}), 32'd0);
         chk("rsp_valid", 32'(RSP_VALID), 32'(k == lat));
         if (k == lat) begin
            chk("rsp_rdata", RSP_RDATA, exp_rd);
            chk("rsp_err", 32'(RSP_ERR), 32'(exp_err));
            chk("ready_during_rsp", 32'(REQ_READY), 32'd0);
         end
         if (k == lat + 1) chk("ready_after_rsp", 32'(REQ_READY), 32'd1);
         tick();
      end
      AXIL_DONE_READ = 1'b0; AXIL_DONE_WRITE = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 32'h0;
      RST = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = 32'h0; REQ_WDATA = 32'h0; REQ_WMASK = 4'h0;
      AXIL_BUSY_READ = 1'b0; AXIL_BUSY_WRITE = 1'b0; AXIL_DONE_READ = 1'b0; AXIL_DONE_WRITE = 1'b0;
      AXIL_TRANSACTION_RDATA = 32'h0;
      repeat (3) tick();
      REQ_VALID = 1'b1; REQ_ADDR = 32'h20; REQ_WMASK = 4'hF;
      @(negedge CLK);
      chk("rst_ready", 32'(REQ_READY), 32'd0);
      chk("rst_dmem_en", 32'({DMEM_EN, DMEM_WMASK}), 32'd0);
      chk("rst_rsp", 32'({RSP_VALID, RSP_ERR}), 32'd0);
      chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
      chk("rst_start", 32'({AXIL_START_READ, AXIL_START_WRITE}), 32'd0);
      chk("rst_raddr", AXIL_TRANSACTION_RADDR | AXIL_TRANSACTION_WRADDR, 32'd0);
      chk("rst_wdata", AXIL_TRANSACTION_WRDATA | 32'(AXIL_TRANSACTION_WSTRB), 32'd0);
      tick();
      REQ_VALID = 1'b0; RST = 1'b0;
      tick();

      // dmem write then read back
      run_req(32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 1'b0);
      run_req(32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0);
      // partial write merges bytes
      run_req(32'h0000_0010, 32'h1122_3344, 4'b0101, 0, 0, 32'h0, 1'b0);
      run_req(32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0);
      // AXIL read, DONE 5 cycles after START
      run_req(32'h4000_0000, 32'h0, 4'h0, 5, 0, 32'h1234_5678, 1'b0);
      // busy hold-off on write channel
      run_req(32'h4000_0004, 32'hCAFE_F00D, 4'b0011, 3, 3, 32'h0, 1'b0);
      // timeout with no DONE, then DONE arriving late in AXIL_RSP and in IDLE
      run_req(32'h4000_0008, 32'h0, 4'h0, 1000, 0, 32'h0, 1'b0);
      run_req(32'h4000_0008, 32'h0, 4'h0, TO + 1, 0, 32'h5555_5555, 1'b0);
      run_req(32'h4000_0008, 32'h0, 4'h0, TO + 2, 0, 32'h6666_6666, 1'b1);
      // DONE on the exact timeout cycle wins
      run_req(32'h4000_000C, 32'h0, 4'h0, TO, 0, 32'hA5A5_A5A5, 1'b0);
      run_req(32'h4000_000C, 32'h0BAD_0BAD, 4'hF, TO, 0, 32'h0, 1'b1);

      // reset asserted asynchronously while in AXIL_WR
      REQ_ADDR = 32'h4000_0010; REQ_WDATA = 32'h7777_7777; REQ_WMASK = 4'hF; REQ_VALID = 1'b1;
      @(negedge CLK);
      chk("rstwr_accept", 32'(REQ_READY), 32'd1);
      tick();
      REQ_ADDR = 32'h20; REQ_VALID = 1'b1;
      #2 RST = 1'b1;
      #1;
      chk("rstwr_ready", 32'(REQ_READY), 32'd0);
      chk("rstwr_dmem", 32'({DMEM_EN, DMEM_WMASK}), 32'd0);
      chk("rstwr_rsp", 32'({RSP_VALID, RSP_ERR}), 32'd0);
      chk("rstwr_rdata", RSP_RDATA, 32'd0);
      chk("rstwr_start", 32'({AXIL_START_READ, AXIL_START_WRITE}), 32'd0);
      chk("rstwr_addr", AXIL_TRANSACTION_RADDR | AXIL_TRANSACTION_WRADDR, 32'd0);
      chk("rstwr_data", AXIL_TRANSACTION_WRDATA | 32'(AXIL_TRANSACTION_WSTRB), 32'd0);
      REQ_VALID = 1'b0;
      tick(); tick();
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge CLK);
         chk("post_rst_quiet", 32'({RSP_VALID, AXIL_START_READ, AXIL_START_WRITE}), 32'd0);
      end
      tick();
      run_req(32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0);

      // randomized mix
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         logic [3:0]  m;
         if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, (1<<AW) - 1)) << 2;
         else                           a = 32'h4000_0000 | ($urandom() & 32'h0FFF_FFFC);
         m = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         run_req(a, $urandom(), m, $urandom_range(1, TO + 3), $urandom_range(0, 3), $urandom(),
                 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
